// File: rtl/battle_sequencer_if.sv
// Signal bundle between the battle sequencer and its surroundings (sprite/HP blocks, VGA pins).
// The master side drives the game/pixel inputs; the slave side is the sequencer itself.
interface battle_sequencer_if #(
    parameter int unsigned N_LAYERS = 8
) ();
    logic                    p_tick;
    logic                    start_pressed;
    logic                    space_pressed;
    logic [9:0]              player_hp;
    logic [9:0]              monster_hp;
    logic [N_LAYERS-1:0]     layer_on;
    logic [12*N_LAYERS-1:0]  layer_rgb;
    logic [11:0]             bg_rgb;
    logic [2:0]              state;
    logic [7:0]              round;
    logic                    phase_done;
    logic [3:0]              vgaRed;
    logic [3:0]              vgaGreen;
    logic [3:0]              vgaBlue;

    modport master (
        output p_tick, start_pressed, space_pressed, player_hp, monster_hp,
        output layer_on, layer_rgb, bg_rgb,
        input  state, round, phase_done, vgaRed, vgaGreen, vgaBlue
    );

    modport slave (
        input  p_tick, start_pressed, space_pressed, player_hp, monster_hp,
        input  layer_on, layer_rgb, bg_rgb,
        output state, round, phase_done, vgaRed, vgaGreen, vgaBlue
    );
endinterface

// File: rtl/battle_sequencer.sv
// Battle phase sequencer (TITLE/DODGE/ATTACK/WIN/LOSE) with a shrinking DODGE window,
// plus a registered priority compositor that turns sprite layers into 12-bit VGA colour.
module battle_sequencer #(
    parameter int unsigned         N_LAYERS     = 8,
    parameter int unsigned         DODGE_CYCLES = 350000000,
    parameter int unsigned         DODGE_STEP   = 25000000,
    parameter int unsigned         DODGE_MIN    = 100000000,
    parameter logic [N_LAYERS-1:0] DODGE_MASK   = N_LAYERS'(8'hFF),
    parameter logic [N_LAYERS-1:0] ATTACK_MASK  = N_LAYERS'(8'hC1),
    parameter int unsigned         TIMER_W      = 29
) (
    input logic               clk,
    input logic               reset,
    battle_sequencer_if.slave bus
);

    localparam int unsigned          DurW    = TIMER_W + 1;
    localparam logic [DurW-1:0]      FloorW  = DurW'(DODGE_MIN) + DurW'(DODGE_STEP);
    localparam logic [TIMER_W-1:0]   DurInit = TIMER_W'(DODGE_CYCLES);
    localparam logic [TIMER_W-1:0]   DurMin  = TIMER_W'(DODGE_MIN);
    localparam logic [TIMER_W-1:0]   DurStep = TIMER_W'(DODGE_STEP);

    typedef enum logic [2:0] {
        StTitle  = 3'd0,
        StDodge  = 3'd1,
        StAttack = 3'd2,
        StWin    = 3'd3,
        StLose   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [TIMER_W-1:0]  dur_q, dur_d;
    logic [TIMER_W-1:0]  dur_shrunk;
    logic [7:0]          round_q, round_d;
    logic                start_armed_q, start_armed_d;
    logic                phase_done_q;
    logic [11:0]         rgb_q, rgb_d;
    logic [N_LAYERS-1:0] mask;
    logic [N_LAYERS-1:0] hit;

    // Threshold compare is widened so MIN+STEP cannot wrap; subtracting is then safe.
    always_comb begin
        if ({1'b0, dur_q} < FloorW) begin
            dur_shrunk = DurMin;
        end else begin
            dur_shrunk = dur_q - DurStep;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        dur_d         = dur_q;
        round_d       = round_q;
        start_armed_d = start_armed_q;

        case (state_q)
            StTitle: begin
                if (!bus.start_pressed) begin
                    start_armed_d = 1'b1;
                end else if (start_armed_q) begin
                    state_d = StDodge;
                    timer_d = '0;
                end
            end
            StDodge: begin
                if (bus.player_hp == '0) begin
                    state_d = StLose;
                end else if (bus.monster_hp == '0) begin
                    state_d = StWin;
                end else if (timer_q == dur_q - TIMER_W'(1)) begin
                    state_d = StAttack;
                    timer_d = '0;
                    dur_d   = dur_shrunk;
                    if (round_q != 8'hFF) begin
                        round_d = round_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StAttack: begin
                if (bus.player_hp == '0) begin
                    state_d = StLose;
                end else if (bus.monster_hp == '0) begin
                    state_d = StWin;
                end else if (bus.space_pressed) begin
                    state_d = StDodge;
                    timer_d = '0;
                end
            end
            StWin, StLose: begin
                if (bus.start_pressed) begin
                    state_d       = StTitle;
                    round_d       = '0;
                    dur_d         = DurInit;
                    start_armed_d = 1'b0;
                end
            end
            default: begin
                state_d       = StTitle;
                start_armed_d = 1'b0;
            end
        endcase
    end

    // Colour follows the state held during the p_tick cycle; reverse scan lets the lowest index win.
    always_comb begin
        case (state_q)
            StDodge:  mask = DODGE_MASK;
            StAttack: mask = ATTACK_MASK;
            default:  mask = '0;
        endcase
        hit   = bus.layer_on & mask;
        rgb_d = rgb_q;
        if (bus.p_tick) begin
            rgb_d = (state_q == StDodge) ? bus.bg_rgb : 12'h000;
            for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
                if (hit[i]) begin
                    rgb_d = bus.layer_rgb[12*i +: 12];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StTitle;
            timer_q       <= '0;
            dur_q         <= DurInit;
            round_q       <= '0;
            start_armed_q <= 1'b1;
            phase_done_q  <= 1'b0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            dur_q         <= dur_d;
            round_q       <= round_d;
            start_armed_q <= start_armed_d;
            phase_done_q  <= (state_d != state_q);
            rgb_q         <= rgb_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.round      = round_q;
    assign bus.phase_done = phase_done_q;
    assign bus.vgaRed     = rgb_q[11:8];
    assign bus.vgaGreen   = rgb_q[7:4];
    assign bus.vgaBlue    = rgb_q[3:0];

endmodule
